button_step_pulser: RTL
=======================

// Module: button_step_pulser
// PURPOSE
//  Conditions the raw board push-buttons into the one-cycle step strobes button_up/button_down.
//  The threshold block consumes these strobes. It adds +/-2 on every cycle a strobe is high.
//  Per button: 2FF synchronize -> debounce -> one pulse per press, plus optional timed auto-repeat.
//  Sits between the top-level button pins and the threshold logic in the camera pipeline.
// PARAMETERS
//  SYNC_STAGES          2        synchronizer flops per button (>=2)
//  DEBOUNCE_CYCLES      1000000  consecutive stable cycles required to accept a level change (>=1)
//  REPEAT_DELAY_CYCLES  50000000 hold time after the first pulse before auto-repeat starts (>=1)
//  REPEAT_PERIOD_CYCLES 10000000 spacing between auto-repeat pulses (>=1)
// PORTS
//  clk           in   1  system clock; all logic on posedge
//  rst_n         in   1  asynchronous active-low reset
//  btn_up_raw    in   1  raw up button, active-high, asynchronous, bouncy
//  btn_down_raw  in   1  raw down button, active-high, asynchronous, bouncy
//  button_up     out  1  single-cycle step-up strobe
//  button_down   out  1  single-cycle step-down strobe
// BEHAVIOUR
//  - Reset (rst_n=0, async assert, sync release): sync flops, debounced levels, counters, strobes = 0.
//    Both FSMs go to IDLE. A press in progress at reset is dropped; it produces a pulse only after
//    reset is released and the full debounce completes.
//  - Debounce, per channel:
//    - The counter increments while the sync output differs from the debounced level.
//    - It clears on any cycle where they match.
//    - At DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
//    - Glitches shorter than DEBOUNCE_CYCLES never propagate.
//  - Latency: raw rise first sampled at edge 0, held stable -> strobe high for exactly one cycle,
//    starting at edge SYNC_STAGES+DEBOUNCE_CYCLES. Release has the same debounce but emits nothing.
//  - Strobe FSM, per channel:
//    - IDLE: on the debounced rising edge, pulse 1 cycle -> HOLD. Repeat counter cleared.
//    - HOLD: count to REPEAT_DELAY_CYCLES; at terminal, if still pressed, pulse -> REPEAT.
//    - REPEAT: pulse every REPEAT_PERIOD_CYCLES while pressed.
//    - HOLD or REPEAT: a debounced release returns to IDLE on the next edge with no pulse.
//      The counter clears.
//  - Simultaneous press (both debounced high in the same cycle):
//    - Both strobes are forced 0. Both FSMs enter LOCK.
//    - LOCK exits to IDLE only once both debounced levels are 0.
//    - A button still held after the other is released never fires. It must be re-pressed.
//  - Invariant: button_up & button_down is never 1. A strobe is never high 2 consecutive cycles.
//  - Counters are sized $clog2(param+1) and saturate at terminal; they never wrap.
// CONFIGURATION
//  - BUTTON_AUTOREPEAT_EN defined: HOLD/REPEAT behave as above.
//  - Undefined: REPEAT_* parameters are unused and no repeat counter is synthesized.
//    After the press pulse the FSM waits in HOLD, with no further pulses, until release or lock.
// STRUCTURE
//  - Package btn_step_pkg:
//    - state enum IDLE/HOLD/REPEAT/LOCK (2-bit)
//    - localparam STROBE_W=1
//    - function for counter width
//  - Sub-module btn_debounce:
//    - synchronizer + debounce counter; outputs level and rise flag
//    - instantiated twice
//  - The top holds both FSMs, the repeat counters and the cross-channel LOCK logic.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=8)
//  1. Clean press: btn_up_raw 0->1 at edge 0, held 10 cycles, released
//     -> button_up high exactly at edge 6, one cycle only; button_down stays 0.
//  2. Bounce: btn_down_raw toggles every 2 cycles for 12 cycles, then stable 1
//     -> exactly one button_down pulse, 6 cycles after the stable start.
//  3. Auto-repeat (macro on): hold up 60 cycles
//     -> pulses at edges 6, 26, 34, 42, 50, 58; release -> no further pulses.
//     Macro off: single pulse at edge 6.
//  4. Simultaneous: up pressed, down pressed 1 cycle later, both held 30 cycles,
//     then down released with up held 20 more cycles
//     -> one up pulse at edge 6 only; nothing after the lock.
//  5. Reset mid-press: rst_n=0 at edge 3 for 2 cycles, up held throughout
//     -> no pulse before release of reset; one pulse 6 cycles after rst_n rises; outputs 0 during reset.

Source files
------------

// File: rtl/btn_step_pkg.sv
// Shared types and helpers for the push-button step pulser.
package btn_step_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } step_state_e;

    localparam int STROBE_W = 1;

    // Width of a counter that must be able to hold the value 'terminal'.
    function automatic int cnt_width(input int terminal);
        return (terminal < 1) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: N-flop synchronizer followed by a stable-count debouncer.
// 'rise' is a one-cycle flag coincident with the debounced level going high.
module btn_debounce
    import btn_step_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            rise   <= 1'b0;
            // Any cycle that agrees with the accepted level restarts the stability run.
            if (sync_q[SYNC_STAGES-1] == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_TERM) begin
                level <= ~level;
                rise  <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/button_step_pulser.sv
// Turns the raw up/down buttons into one-cycle step strobes, locking out simultaneous presses.
// Define BUTTON_AUTOREPEAT_EN to emit timed repeat strobes while a button is held.
module button_step_pulser
    import btn_step_pkg::*;
#(
    parameter int SYNC_STAGES          = 2,
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int REPEAT_DELAY_CYCLES  = 50000000,
    parameter int REPEAT_PERIOD_CYCLES = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic button_up,
    output logic button_down
);
    logic [1:0] raw, lvl, rise;
    logic       both_hi, both_lo;

    assign raw     = {btn_down_raw, btn_up_raw};
    assign both_hi = &lvl;
    assign both_lo = ~|lvl;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RW = cnt_width(RPT_MAX);
    localparam logic [RW-1:0] RPT_DELAY_TERM  = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RPT_PERIOD_TERM = RW'(REPEAT_PERIOD_CYCLES - 1);
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES};
`endif

    for (genvar c = 0; c < 2; c++) begin : g_ch
        step_state_e         state;
        logic [STROBE_W-1:0] strobe;

        btn_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw[c]),
            .level(lvl[c]),
            .rise (rise[c])
        );

`ifdef BUTTON_AUTOREPEAT_EN
        logic [RW-1:0] rcnt;
        logic          term;

        assign term = (state == HOLD) ? (rcnt >= RPT_DELAY_TERM) : (rcnt >= RPT_PERIOD_TERM);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= IDLE;
                strobe <= '0;
                rcnt   <= '0;
            end else begin
                strobe <= '0;
                if (both_hi) begin
                    state <= LOCK;
                    rcnt  <= '0;
                end else begin
                    case (state)
                        IDLE: if (rise[c]) begin
                            strobe <= '1;
                            state  <= HOLD;
                            rcnt   <= '0;
                        end
                        HOLD, REPEAT: begin
                            if (!lvl[c]) begin
                                state <= IDLE;
                                rcnt  <= '0;
                            end else if (!term) begin
                                rcnt <= rcnt + RW'(1);
                            // Counter waits saturated if a strobe is still high, so strobes never abut.
                            end else if (strobe == '0) begin
                                strobe <= '1;
                                state  <= REPEAT;
                                rcnt   <= '0;
                            end
                        end
                        LOCK:    if (both_lo) state <= IDLE;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
`else
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= IDLE;
                strobe <= '0;
            end else begin
                strobe <= '0;
                if (both_hi) begin
                    state <= LOCK;
                end else begin
                    case (state)
                        IDLE: if (rise[c]) begin
                            strobe <= '1;
                            state  <= HOLD;
                        end
                        HOLD, REPEAT: if (!lvl[c]) state <= IDLE;
                        LOCK:         if (both_lo) state <= IDLE;
                        default:      state <= IDLE;
                    endcase
                end
            end
        end
`endif
    end

    assign button_up   = g_ch[0].strobe;
    assign button_down = g_ch[1].strobe;

endmodule
